// File: rtl/craps_game_ctrl.sv
// craps_game_ctrl
//   Sequences one craps game around the dice datapath. The roll button gates
//   the dice counters. The first roll is judged from the decoder flags. Later
//   rolls are compared against the stored point. The win/lose result holds
//   until new_game is requested.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   rb                  roll button (debounced upstream), high = rolling
//   new_game            synchronous clear of the result, starts a new game
//   sum, d7, d711, d2312  dice sum and decoder flags, sampled in EVAL states
//   roll_en             enables the dice counters (Moore)
//   win, lose           held game result (Moore)
//   point, point_valid  stored point and its valid flag
//   roll_cnt            completed valid rolls this game, saturating
//   err                 one-cycle pulse when the sum is out of 2..12 at evaluation
module craps_game_ctrl #(
  parameter int SUM_W = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rb,
  input  logic             new_game,
  input  logic [SUM_W-1:0] sum,
  input  logic             d7,
  input  logic             d711,
  input  logic             d2312,
  output logic             roll_en,
  output logic             win,
  output logic             lose,
  output logic [SUM_W-1:0] point,
  output logic             point_valid,
  output logic [CNT_W-1:0] roll_cnt,
  output logic             err
);

  localparam logic [2:0] S_FIRST      = 3'd0;
  localparam logic [2:0] S_FIRST_ROLL = 3'd1;
  localparam logic [2:0] S_FIRST_EVAL = 3'd2;
  localparam logic [2:0] S_POINT      = 3'd3;
  localparam logic [2:0] S_POINT_ROLL = 3'd4;
  localparam logic [2:0] S_POINT_EVAL = 3'd5;
  localparam logic [2:0] S_WIN        = 3'd6;
  localparam logic [2:0] S_LOSE       = 3'd7;

  localparam logic [SUM_W-1:0] SUM_MIN = SUM_W'(2);
  localparam logic [SUM_W-1:0] SUM_MAX = SUM_W'(12);

  logic [2:0] state, state_d;
  logic       sum_ok;

  assign sum_ok = (sum >= SUM_MIN) && (sum <= SUM_MAX);

  always_comb begin
    state_d = state;
    case (state)
      S_FIRST:      if (rb)  state_d = S_FIRST_ROLL;
      S_FIRST_ROLL: if (!rb) state_d = S_FIRST_EVAL;
      S_FIRST_EVAL: begin
        if (!sum_ok)    state_d = S_FIRST;
        else if (d711)  state_d = S_WIN;
        else if (d2312) state_d = S_LOSE;
        else            state_d = S_POINT;
      end
      S_POINT:      if (rb)  state_d = S_POINT_ROLL;
      S_POINT_ROLL: if (!rb) state_d = S_POINT_EVAL;
      S_POINT_EVAL: begin
        // A point is never 7, so sum==point and d7 are mutually exclusive.
        if (!sum_ok)            state_d = S_POINT;
        else if (sum == point)  state_d = S_WIN;
        else if (d7)            state_d = S_LOSE;
        else                    state_d = S_POINT;
      end
      default: state_d = state; // WIN/LOSE hold until new_game
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FIRST;
      point       <= '0;
      point_valid <= 1'b0;
      roll_cnt    <= '0;
      err         <= 1'b0;
    end else if (new_game) begin
      state       <= S_FIRST;
      point       <= '0;
      point_valid <= 1'b0;
      roll_cnt    <= '0;
      err         <= 1'b0;
    end else begin
      state <= state_d;
      err   <= 1'b0;
      if (state == S_FIRST_EVAL || state == S_POINT_EVAL) begin
        if (!sum_ok) begin
          err <= 1'b1;
        end else begin
          if (roll_cnt != '1) roll_cnt <= roll_cnt + 1'b1;
          if (state == S_FIRST_EVAL && !d711 && !d2312) begin
            point       <= sum;
            point_valid <= 1'b1;
          end
        end
      end
    end
  end

  // Moore outputs: roll_en stays high through the cycle rb is seen low, so
  // the dice take one last step on the edge into EVAL.
  assign roll_en = (state == S_FIRST_ROLL) || (state == S_POINT_ROLL);
  assign win     = (state == S_WIN);
  assign lose    = (state == S_LOSE);

endmodule

// File: tb/tb_craps_game_ctrl.sv
module tb_craps_game_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       rb, new_game, d7, d711, d2312;
  logic [3:0] sum;
  logic       roll_en, win, lose, point_valid, err;
  logic [3:0] point, roll_cnt;

  int checks = 0;
  int failures = 0;

  craps_game_ctrl #(.SUM_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .rb(rb), .new_game(new_game), .sum(sum),
    .d7(d7), .d711(d711), .d2312(d2312), .roll_en(roll_en), .win(win),
    .lose(lose), .point(point), .point_valid(point_valid),
    .roll_cnt(roll_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Hold rb for 'hold' cycles with the dice presented, release it, then let
  // the EVAL cycle complete. Returns right after the result edge.
  task automatic roll(input int hold, input logic [3:0] s,
                      input logic f7, input logic f711, input logic f2312);
    sum = s; d7 = f7; d711 = f711; d2312 = f2312;
    rb = 1'b1;
    for (int i = 0; i < hold; i++) step();
    rb = 1'b0;
    step();   // ROLL -> EVAL
    step();   // EVAL -> result
  endtask

  task automatic restart();
    new_game = 1'b1;
    step();
    new_game = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rb = 1'b0; new_game = 1'b0;
    sum = 4'd0; d7 = 1'b0; d711 = 1'b0; d2312 = 1'b0;
    #12;
    chk("rst_roll_en", roll_en, 0);
    chk("rst_win", win, 0);
    chk("rst_lose", lose, 0);
    chk("rst_point", point, 0);
    chk("rst_pv", point_valid, 0);
    chk("rst_cnt", roll_cnt, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    step();

    // Natural 7 on the first roll, with per-cycle latency checks
    sum = 4'd7; d7 = 1'b1; d711 = 1'b1; d2312 = 1'b0;
    rb = 1'b1;
    step();
    chk("g1_roll_en_rise", roll_en, 1);
    step(); step();
    chk("g1_roll_en_hold", roll_en, 1);
    rb = 1'b0;
    step();
    chk("g1_eval_roll_en", roll_en, 0);
    chk("g1_eval_win", win, 0);
    step();
    chk("g1_win", win, 1);
    chk("g1_cnt", roll_cnt, 1);
    chk("g1_pv", point_valid, 0);
    roll(2, 4'd3, 0, 0, 1);
    chk("g1_win_held", win, 1);
    chk("g1_lose_low", lose, 0);
    chk("g1_no_roll", roll_en, 0);
    chk("g1_cnt_held", roll_cnt, 1);
    restart();
    chk("ng_win", win, 0);
    chk("ng_cnt", roll_cnt, 0);

    // Craps 12
    roll(3, 4'd12, 0, 0, 1);
    chk("g2_lose", lose, 1);
    chk("g2_win", win, 0);
    chk("g2_cnt", roll_cnt, 1);
    restart();

    // Point 5, miss with 8, make it with 5
    roll(3, 4'd5, 0, 0, 0);
    chk("g3_point", point, 5);
    chk("g3_pv", point_valid, 1);
    chk("g3_cnt1", roll_cnt, 1);
    roll(2, 4'd8, 0, 0, 0);
    chk("g3_miss_win", win, 0);
    chk("g3_miss_lose", lose, 0);
    chk("g3_miss_point", point, 5);
    chk("g3_cnt2", roll_cnt, 2);
    roll(1, 4'd5, 0, 0, 0);
    chk("g3_win", win, 1);
    chk("g3_cnt3", roll_cnt, 3);
    restart();

    // Point 6, invalid sum in point phase, then seven-out (d711 ignored)
    roll(3, 4'd6, 0, 0, 0);
    chk("g4_point", point, 6);
    roll(2, 4'd13, 0, 0, 0);
    chk("g4_err", err, 1);
    chk("g4_err_cnt", roll_cnt, 1);
    chk("g4_err_point", point, 6);
    step();
    chk("g4_err_pulse", err, 0);
    roll(2, 4'd7, 1, 1, 0);
    chk("g4_lose", lose, 1);
    chk("g4_win", win, 0);
    chk("g4_point_kept", point, 6);
    chk("g4_cnt", roll_cnt, 2);
    restart();

    // Invalid first roll, then natural 11
    roll(3, 4'd1, 0, 0, 0);
    chk("g5_err", err, 1);
    chk("g5_cnt", roll_cnt, 0);
    chk("g5_pv", point_valid, 0);
    step();
    chk("g5_err_pulse", err, 0);
    chk("g5_idle", roll_en, 0);
    roll(2, 4'd11, 0, 1, 0);
    chk("g5_win", win, 1);
    chk("g5_cnt1", roll_cnt, 1);
    restart();

    // new_game during the point roll
    roll(3, 4'd9, 0, 0, 0);
    chk("g6_point", point, 9);
    rb = 1'b1;
    step(); step();
    chk("g6_rolling", roll_en, 1);
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    chk("g6_roll_en", roll_en, 0);
    chk("g6_point0", point, 0);
    chk("g6_pv0", point_valid, 0);
    chk("g6_cnt0", roll_cnt, 0);
    rb = 1'b0;
    step(); step();
    chk("g6_idle", roll_en, 0);

    // Counter saturation: point 4, then 16 misses with 8 => 17 valid rolls
    roll(1, 4'd4, 0, 0, 0);
    for (int i = 0; i < 16; i++) roll(1, 4'd8, 0, 0, 0);
    chk("sat_cnt", roll_cnt, 15);
    chk("sat_point", point, 4);
    restart();

    // Asynchronous reset mid-roll with a point held
    roll(2, 4'd10, 0, 0, 0);
    rb = 1'b1;
    step();
    chk("ar_rolling", roll_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_roll_en", roll_en, 0);
    chk("ar_point", point, 0);
    chk("ar_pv", point_valid, 0);
    chk("ar_cnt", roll_cnt, 0);
    chk("ar_win", win, 0);
    chk("ar_lose", lose, 0);
    rb = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("ar_after", roll_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
